// File: rtl/mux_key_with_default.sv
// mux_key_with_default: keyed lookup multiplexer with default value.
//
// Compares `key` against NR_KEY packed (key, data) pairs in `lut`. The result
// is the data of the lowest-index matching pair, or `default_out` when no pair
// matches. The selection is combinational with zero latency. A registered copy
// of the result and of the hit flag is loaded on enabled clock edges.
//
// Optional feature macro: MUXKEY_MULTI_HIT_EN
//   defined   - multi_hit flags two or more matching pairs. A simulation-only
//               warning is printed on each unreset rising edge that sees it.
//   undefined - multi_hit is tied to 0.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous reset, active-high (clears out_q/hit_q)
//   en          in   load enable for out_q/hit_q
//   key         in   [KEY_LEN-1:0] lookup key
//   default_out in   [DATA_LEN-1:0] value driven when no pair matches
//   lut         in   [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] packed pairs. Pair i is at
//                    [PAIR_LEN*(i+1)-1 : PAIR_LEN*i], with the key in its upper
//                    KEY_LEN bits and the data in its lower DATA_LEN bits.
//   out         out  [DATA_LEN-1:0] combinational selected value
//   hit         out  combinational: at least one pair matched
//   out_q       out  [DATA_LEN-1:0] registered out
//   hit_q       out  registered hit
//   multi_hit   out  combinational: two or more pairs matched (feature only)
module mux_key_with_default #(
  parameter int unsigned NR_KEY   = 2,
  parameter int unsigned KEY_LEN  = 1,
  parameter int unsigned DATA_LEN = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic [KEY_LEN-1:0]                     key,
  input  logic [DATA_LEN-1:0]                    default_out,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]   lut,
  output logic [DATA_LEN-1:0]                    out,
  output logic                                   hit,
  output logic [DATA_LEN-1:0]                    out_q,
  output logic                                   hit_q,
  output logic                                   multi_hit
);

  localparam int unsigned PairLen = KEY_LEN + DATA_LEN;

  logic [NR_KEY-1:0] match;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NR_KEY; i++) begin
      match[i] = (lut[PairLen*i + DATA_LEN +: KEY_LEN] == key);
    end
  end

  // Walk from the highest index down so the lowest-index match is written last
  // and wins. Data is selected, never ORed, when several pairs match.
  always_comb begin
    out = default_out;
    for (int i = int'(NR_KEY) - 1; i >= 0; i--) begin
      if (match[i]) begin
        out = lut[PairLen*i +: DATA_LEN];
      end
    end
  end

  assign hit = |match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      hit_q <= 1'b0;
    end else if (en) begin
      out_q <= out;
      hit_q <= hit;
    end
  end

`ifdef MUXKEY_MULTI_HIT_EN
  localparam logic [NR_KEY-1:0] One = 1;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_hit = |(match & (match - One));

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && multi_hit) begin
      $warning("mux_key_with_default: multiple pairs match key %h, lowest index used", key);
    end
  end
`endif
`else
  assign multi_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mux_key_with_default.sv
// Scoreboard bench for mux_key_with_default: stimulus pushes hand-computed
// expectations into a queue; a monitor on the falling edge pops and compares.
module tb_mux_key_with_default;

  logic clk = 1'b0;
  logic rst;
  logic en;

  always #5 clk = ~clk;

  // Main configuration: 3 pairs, 7-bit keys, 32-bit data.
  logic [6:0]   key_b;
  logic [31:0]  def_b;
  logic [116:0] lut_b;
  logic [31:0]  out_b, outq_b;
  logic         hit_b, hitq_b, mh_b;

  // Duplicate-key configuration: 2 pairs, 4-bit keys, 4-bit data.
  logic [3:0] key_d, def_d, out_d, outq_d;
  logic [15:0] lut_d;
  logic       hit_d, hitq_d, mh_d;

  // Minimal configuration: 1 pair, 1-bit key, 1-bit data.
  logic       key_m, def_m, out_m, outq_m, hit_m, hitq_m, mh_m;
  logic [1:0] lut_m;

  mux_key_with_default #(.NR_KEY(3), .KEY_LEN(7), .DATA_LEN(32)) u_big (
    .clk(clk), .rst(rst), .en(en), .key(key_b), .default_out(def_b), .lut(lut_b),
    .out(out_b), .hit(hit_b), .out_q(outq_b), .hit_q(hitq_b), .multi_hit(mh_b)
  );

  mux_key_with_default #(.NR_KEY(2), .KEY_LEN(4), .DATA_LEN(4)) u_dup (
    .clk(clk), .rst(rst), .en(en), .key(key_d), .default_out(def_d), .lut(lut_d),
    .out(out_d), .hit(hit_d), .out_q(outq_d), .hit_q(hitq_d), .multi_hit(mh_d)
  );

  mux_key_with_default #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(1)) u_min (
    .clk(clk), .rst(rst), .en(en), .key(key_m), .default_out(def_m), .lut(lut_m),
    .out(out_m), .hit(hit_m), .out_q(outq_m), .hit_q(hitq_m), .multi_hit(mh_m)
  );

  typedef enum int {SigOut, SigHit, SigOutQ, SigHitQ, SigMulti,
                    SigDupOut, SigDupHit, SigDupMulti, SigMinOut, SigMinHit} sig_e;

  typedef struct {
    sig_e        sig;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

`ifdef MUXKEY_MULTI_HIT_EN
  localparam logic DupMultiExp = 1'b1;
`else
  localparam logic DupMultiExp = 1'b0;
`endif

  function automatic logic [31:0] actual(input sig_e s);
    case (s)
      SigOut:      return out_b;
      SigHit:      return {31'd0, hit_b};
      SigOutQ:     return outq_b;
      SigHitQ:     return {31'd0, hitq_b};
      SigMulti:    return {31'd0, mh_b};
      SigDupOut:   return {28'd0, out_d};
      SigDupHit:   return {31'd0, hit_d};
      SigDupMulti: return {31'd0, mh_d};
      SigMinOut:   return {31'd0, out_m};
      default:     return {31'd0, hit_m};
    endcase
  endfunction

  task automatic push(input sig_e s, input logic [31:0] e, input string n);
    chk_t c;
    c.sig  = s;
    c.exp  = e;
    c.name = n;
    sb.push_back(c);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t c;
      logic [31:0] a;
      c = sb.pop_front();
      a = actual(c.sig);
      n_checks++;
      if (a === c.exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", c.name, a, c.exp, $time);
    end
  end

  // Bench-side model of the registered stage of u_big.
  logic        cur_en;
  logic [31:0] cur_out, mq_out;
  logic        cur_hit, mq_hit;

  task automatic edge_model();
    if (rst) begin
      mq_out = '0;
      mq_hit = 1'b0;
    end else if (cur_en) begin
      mq_out = cur_out;
      mq_hit = cur_hit;
    end
  endtask

  task automatic step(input logic [6:0] k, input logic e, input logic [31:0] d,
                      input logic [31:0] eo, input logic eh, input string tag);
    @(posedge clk);
    edge_model();
    #1;
    key_b = k; en = e; def_b = d;
    cur_en = e; cur_out = eo; cur_hit = eh;
    push(SigOut, eo, {tag, ".out"});
    push(SigHit, {31'd0, eh}, {tag, ".hit"});
    push(SigOutQ, mq_out, {tag, ".out_q"});
    push(SigHitQ, {31'd0, mq_hit}, {tag, ".hit_q"});
    push(SigMulti, 32'd0, {tag, ".multi_hit"});
  endtask

  localparam logic [6:0] KA = 7'b0010111;  // pair 2, data 8000_0000
  localparam logic [6:0] KB = 7'b0110111;  // pair 1, data 0
  localparam logic [6:0] KC = 7'b1101111;  // pair 0, data 8000_0010
  localparam logic [6:0] KX = 7'b0010011;  // no match

  initial begin
    rst = 1'b1; en = 1'b0;
    key_b = 7'd0; def_b = 32'h1234;
    lut_b = {KA, 32'h8000_0000, KB, 32'h0, KC, 32'h8000_0010};
    key_d = 4'd5; def_d = 4'h7; lut_d = {4'd5, 4'hB, 4'd5, 4'hA};
    key_m = 1'b1; def_m = 1'b1; lut_m = 2'b10;
    cur_en = 1'b0; cur_out = '0; cur_hit = 1'b0; mq_out = '0; mq_hit = 1'b0;

    // Reset state; combinational path stays live under reset.
    @(posedge clk); #1;
    push(SigOutQ, 32'd0, "reset.out_q");
    push(SigHitQ, 32'd0, "reset.hit_q");
    push(SigOut, 32'h1234, "reset.out_default");
    push(SigHit, 32'd0, "reset.hit");
    // Duplicate keys: lowest index wins, no OR of data.
    push(SigDupOut, 32'hA, "dup.out");
    push(SigDupHit, 32'd1, "dup.hit");
    push(SigDupMulti, {31'd0, DupMultiExp}, "dup.multi_hit");
    // Minimal configuration, matching key.
    push(SigMinOut, 32'd0, "min.match_out");
    push(SigMinHit, 32'd1, "min.match_hit");
    @(negedge clk); #1;
    rst = 1'b0;

    step(KB, 1'b1, 32'h1234, 32'h0, 1'b1, "kb");
    key_d = 4'd3; key_m = 1'b0;
    push(SigDupOut, 32'h7, "dup.miss_out");
    push(SigDupHit, 32'd0, "dup.miss_hit");
    push(SigDupMulti, 32'd0, "dup.miss_multi");
    push(SigMinOut, 32'd1, "min.miss_out");
    push(SigMinHit, 32'd0, "min.miss_hit");

    step(KC, 1'b1, 32'h1234, 32'h8000_0010, 1'b1, "kc");
    lut_d = {4'd5, 4'hB, 4'd2, 4'hA}; key_d = 4'd5;
    push(SigDupOut, 32'hB, "dup.pair1_out");
    push(SigDupMulti, 32'd0, "dup.single_multi");

    step(KA, 1'b1, 32'h1234, 32'h8000_0000, 1'b1, "ka");
    step(KX, 1'b0, 32'h1234, 32'h1234, 1'b0, "miss");
    step(KB, 1'b0, 32'h1234, 32'h0, 1'b1, "hold1");
    step(KX, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "hold2");

    // Asynchronous reset between edges.
    @(posedge clk);
    edge_model();
    #1;
    rst = 1'b1;
    mq_out = '0; mq_hit = 1'b0;
    push(SigOutQ, 32'd0, "async.out_q");
    push(SigHitQ, 32'd0, "async.hit_q");
    push(SigOut, 32'hDEAD_BEEF, "async.out");
    @(negedge clk); #1;
    rst = 1'b0;

    step(KC, 1'b0, 32'h1234, 32'h8000_0010, 1'b0 | 1'b1, "post_rst_en0");
    step(KC, 1'b1, 32'h1234, 32'h8000_0010, 1'b1, "post_rst_load");
    step(KB, 1'b1, 32'h1234, 32'h0, 1'b1, "post_rst_follow");

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
